fetch_decode_unit: RTL
======================

Name: fetch_decode_unit

Overview:
- Instruction fetch and field-decode stage directly upstream of the main control unit.
- Holds the PC and issues one word fetch at a time to instruction memory over a req/gnt/rvalid handshake.
- Captures each returned instruction and presents opcode/funct3/funct7/register fields to the control unit with a valid/ready handshake.
- Accepts branch redirects from the execute stage and flushes in-flight work.

Parameters:
- XLEN, 32, width of the PC and instruction word.
- RESET_PC, 32'h0000_0000, PC value loaded on reset; bits [1:0] must be 0.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- imem_req  out  1  fetch request valid.
- imem_addr  out  XLEN  fetch byte address; always word aligned.
- imem_gnt  in  1  request accepted this cycle.
- imem_rvalid  in  1  response data valid; at most one per granted request, never in the grant cycle.
- imem_rdata  in  XLEN  instruction word.
- redirect_valid  in  1  branch taken; load a new PC.
- redirect_pc  in  XLEN  redirect target; bits [1:0] are ignored and forced to 0.
- out_valid  out  1  decoded instruction valid.
- out_ready  in  1  control stage accepts the instruction.
- out_pc  out  XLEN  PC of the presented instruction.
- opcode  out  7  instr[6:0].
- funct3  out  3  instr[14:12].
- funct7  out  7  instr[31:25].
- rd, rs1, rs2  out  5 each  instr[11:7], [19:15], [24:20].

Behaviour:
- Reset (synchronous, checked first every edge):
  - pc = RESET_PC; state = REQ; discard = 0.
  - out_valid = 0; out_pc = 0; all field outputs = 0.
  - imem_req = 0 in the reset cycle.
- FSM, three states:
  - REQ: imem_req = 1, imem_addr = pc. Request is issued only if the output register is empty or is being consumed this cycle (out_valid & out_ready); otherwise imem_req = 0 and the FSM waits in REQ. On imem_gnt go to WAIT.
  - WAIT: imem_req = 0. On imem_rvalid with discard = 0: capture imem_rdata into the output register, set out_valid = 1, out_pc = pc, pc = pc + 4 (wraps modulo 2^XLEN, 32'hFFFF_FFFC to 0), go to REQ. On imem_rvalid with discard = 1: drop the data, clear discard, go to REQ.
  - HOLD is implicit: out_valid stays 1 and all outputs are stable until out_ready.
- Handshake:
  - The instruction transfers on the cycle where out_valid & out_ready; out_valid then clears unless a new capture happens in the same cycle.
  - Outputs must not change while out_valid = 1 and out_ready = 0.
- Latency: the first out_valid occurs 2 cycles after grant for a 1-cycle memory (grant cycle, then rvalid, then registered output). Steady-state throughput is 1 instruction per 2 cycles with a 1-cycle memory.
- Redirect has priority over all other events in the same cycle:
  - pc = {redirect_pc[XLEN-1:2], 2'b00}; out_valid = 0.
  - If in WAIT with no rvalid this cycle: set discard = 1.
  - If in WAIT with rvalid this cycle: drop the data, discard stays 0, go to REQ.
  - If in REQ and a grant occurs this cycle: go to WAIT with discard = 1 (the stale request is dropped).
  - imem_addr during the redirect cycle is the old pc; the new pc is used from the next cycle.
- Redirect while out_valid & out_ready: the transfer still counts; out_valid clears.
- Back-to-back redirects: the last one wins; discard never exceeds one pending response.
- A reset mid-transaction abandons any outstanding response. The memory must be reset in the same cycle.

Optional Feature:
- Macro: FETCH_ILLEGAL_CHK_EN.
- When defined:
  - Extra output port out_illegal (1 bit), registered with the other fields and reset to 0.
  - It is 1 when instr[1:0] != 2'b11, or the opcode is not one of 0000011, 0100011, 0110011, 1100011, 0010011, 1101111, 1100111, 0110111, 0010111, 1110011.
  - Flow control is unaffected.
- When undefined: the port does not exist and no check logic is generated.

Decomposition:
- Shared package: XLEN default, opcode localparams (OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM), FSM state encoding, field bit-position constants.
- One sub-module: fetch_out_reg, which holds the output register, the valid/ready logic and field slicing. The FSM and PC stay in the top module.

Test Plan:
- Reset release, memory returns 32'h00C12283 (lw x5,12(x2)) one cycle after grant at address 0. Required: opcode=0000011, funct3=010, rd=5, rs1=2, out_pc=0, out_valid at cycle 3 after reset.
- Stream sw 32'h00EB2823, sub 32'h41F481B3, beq 32'h00B40463 with out_ready=1. Required: out_pc 4, 8, C; sub shows funct7=0100000; beq shows opcode=1100011.
- Hold out_ready=0 for 5 cycles with out_valid=1. Required: outputs stable, imem_req=0, pc unchanged; fetching resumes the cycle out_ready rises.
- Assert redirect_valid with redirect_pc=32'h0000_0103 while in WAIT. Required: the stale rvalid is dropped, out_valid stays 0, next imem_addr = 32'h0000_0100.
- Set RESET_PC=32'hFFFF_FFFC and fetch two instructions. Required: out_pc FFFF_FFFC then 0000_0000.
- With FETCH_ILLEGAL_CHK_EN, fetch 32'h0000_0000 then 32'h00000013. Required: out_illegal 1, then 0.

Source files
------------

// File: rtl/fetch_decode_unit_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_decode_unit_pkg
//  Purpose  : Shared definitions for the fetch/decode stage: default width,
//             base-ISA major opcodes, FSM state encoding, instruction field
//             bit positions and the illegal-opcode helper used when the
//             FETCH_ILLEGAL_CHK_EN build option is enabled.
//  Revision : 1.0  initial release
// ============================================================================
package fetch_decode_unit_pkg;

    localparam int XLEN_DEFAULT = 32;
    localparam int INSTR_W      = 32;

    // Major opcodes recognised by the downstream control unit
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    // Fetch FSM. HOLD has no encoding of its own: it is REQ with the
    // request gated off while the output register is full and stalled.
    typedef enum logic [1:0] {
        ST_REQ  = 2'd0,
        ST_WAIT = 2'd1
    } fetch_state_e;

    // Instruction field bit positions
    localparam int OPC_MSB = 6;
    localparam int OPC_LSB = 0;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 7;
    localparam int F3_MSB  = 14;
    localparam int F3_LSB  = 12;
    localparam int RS1_MSB = 19;
    localparam int RS1_LSB = 15;
    localparam int RS2_MSB = 24;
    localparam int RS2_LSB = 20;
    localparam int F7_MSB  = 31;
    localparam int F7_LSB  = 25;

    // 1 when the word is compressed/invalid (low bits != 11) or its major
    // opcode is outside the supported set.
    function automatic logic is_illegal(input logic [INSTR_W-1:0] instr);
        logic known;
        case (instr[OPC_MSB:OPC_LSB])
            OP_LOAD, OP_STORE, OP_RTYPE, OP_BRANCH, OP_ITYPE,
            OP_JAL, OP_JALR, OP_LUI, OP_AUIPC, OP_SYSTEM: known = 1'b1;
            default:                                      known = 1'b0;
        endcase
        return (instr[1:0] != 2'b11) || !known;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_decode_unit_out_reg.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_out_reg
//  Purpose  : Output register of the fetch/decode stage. Holds one captured
//             instruction and its PC, runs the valid/ready handshake toward
//             the control unit and slices the decode fields.
//  Ports    : clk, reset       - clock, synchronous active-high reset
//             load_i           - capture pc_i/instr_i this cycle
//             flush_i          - redirect: drop the held instruction
//             out_ready_i      - consumer accepts the held instruction
//             out_valid_o, out_pc_o, opcode_o, funct3_o, funct7_o,
//             rd_o, rs1_o, rs2_o - registered decode outputs
//             out_illegal_o    - only with FETCH_ILLEGAL_CHK_EN defined
//  Revision : 1.0  initial release
// ============================================================================
module fetch_out_reg
    import fetch_decode_unit_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_i,
    input  logic               flush_i,
    input  logic [XLEN-1:0]    pc_i,
    input  logic [INSTR_W-1:0] instr_i,
    input  logic               out_ready_i,
    output logic               out_valid_o,
    output logic [XLEN-1:0]    out_pc_o,
    output logic [6:0]         opcode_o,
    output logic [2:0]         funct3_o,
    output logic [6:0]         funct7_o,
    output logic [4:0]         rd_o,
    output logic [4:0]         rs1_o,
    output logic [4:0]         rs2_o
`ifdef FETCH_ILLEGAL_CHK_EN
    ,
    output logic               out_illegal_o
`endif
);

    logic               valid_q, valid_d;
    logic [XLEN-1:0]    pc_q, pc_d;
    logic [INSTR_W-1:0] instr_q, instr_d;

    // Flush outranks everything; a transfer in the flush cycle still
    // counts because the consumer sampled valid/ready before the edge.
    always_comb begin
        valid_d = valid_q;
        pc_d    = pc_q;
        instr_d = instr_q;
        if (flush_i) begin
            valid_d = 1'b0;
        end else if (load_i) begin
            valid_d = 1'b1;
            pc_d    = pc_i;
            instr_d = instr_i;
        end else if (valid_q && out_ready_i) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= 1'b0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            valid_q <= valid_d;
            pc_q    <= pc_d;
            instr_q <= instr_d;
        end
    end

`ifdef FETCH_ILLEGAL_CHK_EN
    logic illegal_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            illegal_q <= 1'b0;
        end else if (!flush_i && load_i) begin
            illegal_q <= is_illegal(instr_i);
        end
    end

    assign out_illegal_o = illegal_q;
`endif

    assign out_valid_o = valid_q;
    assign out_pc_o    = pc_q;
    assign opcode_o    = instr_q[OPC_MSB:OPC_LSB];
    assign rd_o        = instr_q[RD_MSB:RD_LSB];
    assign funct3_o    = instr_q[F3_MSB:F3_LSB];
    assign rs1_o       = instr_q[RS1_MSB:RS1_LSB];
    assign rs2_o       = instr_q[RS2_MSB:RS2_LSB];
    assign funct7_o    = instr_q[F7_MSB:F7_LSB];

endmodule
`default_nettype wire

// File: rtl/fetch_decode_unit.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_decode_unit
//  Purpose  : Instruction fetch + field decode in front of the control unit.
//             Keeps the PC, issues one word fetch at a time over a
//             req/gnt/rvalid port, and hands decoded fields downstream with
//             valid/ready. Branch redirects reload the PC and drop any
//             in-flight response.
//  Ports    : clk, reset (sync, active-high)
//             imem_req/imem_addr/imem_gnt/imem_rvalid/imem_rdata - memory
//             redirect_valid/redirect_pc                         - execute
//             out_valid/out_ready/out_pc/opcode/funct3/funct7/rd/rs1/rs2
//             out_illegal - present only with FETCH_ILLEGAL_CHK_EN defined
//  Build    : `define FETCH_ILLEGAL_CHK_EN adds the illegal-opcode flag.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_decode_unit
    import fetch_decode_unit_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEFAULT,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            reset,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [XLEN-1:0] imem_rdata,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [6:0]      opcode,
    output logic [2:0]      funct3,
    output logic [6:0]      funct7,
    output logic [4:0]      rd,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2
`ifdef FETCH_ILLEGAL_CHK_EN
    ,
    output logic            out_illegal
`endif
);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic            discard_q, discard_d;
    logic            w_can_issue;
    logic            w_grant;
    logic            w_capture;

    // Only one instruction may be buffered, so a new fetch is issued only
    // when the output slot is empty or drains this cycle.
    assign w_can_issue = !out_valid || out_ready;
    assign imem_req    = !reset && (state_q == ST_REQ) && w_can_issue;
    assign imem_addr   = pc_q;
    assign w_grant     = imem_req && imem_gnt;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        discard_d = discard_q;
        w_capture = 1'b0;
        if (redirect_valid) begin
            pc_d = redirect_pc & ~XLEN'(3);
            case (state_q)
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = ST_REQ;
                        discard_d = 1'b0;
                    end else begin
                        discard_d = 1'b1;
                    end
                end
                ST_REQ: begin
                    // A request granted now belongs to the old path.
                    if (w_grant) begin
                        state_d   = ST_WAIT;
                        discard_d = 1'b1;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end else begin
            case (state_q)
                ST_WAIT: begin
                    if (imem_rvalid) begin
                        state_d   = ST_REQ;
                        discard_d = 1'b0;
                        if (!discard_q) begin
                            w_capture = 1'b1;
                            pc_d      = pc_q + XLEN'(4);
                        end
                    end
                end
                ST_REQ: begin
                    if (w_grant) begin
                        state_d = ST_WAIT;
                    end
                end
                default: state_d = ST_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_REQ;
            pc_q      <= RESET_PC;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            discard_q <= discard_d;
        end
    end

    fetch_out_reg #(
        .XLEN (XLEN)
    ) u_out_reg (
        .clk           (clk),
        .reset         (reset),
        .load_i        (w_capture),
        .flush_i       (redirect_valid),
        .pc_i          (pc_q),
        .instr_i       (imem_rdata[INSTR_W-1:0]),
        .out_ready_i   (out_ready),
        .out_valid_o   (out_valid),
        .out_pc_o      (out_pc),
        .opcode_o      (opcode),
        .funct3_o      (funct3),
        .funct7_o      (funct7),
        .rd_o          (rd),
        .rs1_o         (rs1),
        .rs2_o         (rs2)
`ifdef FETCH_ILLEGAL_CHK_EN
        ,
        .out_illegal_o (out_illegal)
`endif
    );

endmodule
`default_nettype wire
